// File: rtl/add_byte_sequencer.sv
// -----------------------------------------------------------------------------
// add_byte_sequencer
//
// Byte-serial multi-byte adder controller. Operand slices arrive LSB first on a
// valid/ready stream and are passed through to an external WIDTH-bit adder.
// The block feeds the adder's carry-out back in as the next slice's carry-in,
// so one NBYTES x WIDTH-bit sum is built from a single WIDTH-bit adder. Each
// result slice is registered and presented on a valid/ready output stream.
//
// Optional feature macro: SEQ_SUB_EN
//   When defined, adds in_sub. in_sub is sampled on slice 0 and held for the
//   whole word. While it is set the block computes A - B as A + ~B + 1, and
//   out_co=1 means "no borrow".
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready operand slice handshake
//   in_a, in_b        operand slices
//   ci_init           word carry-in, sampled on slice 0 only
//   in_sub            (SEQ_SUB_EN only) subtract select, sampled on slice 0
//   add_a/add_b/add_ci  drive to the external adder
//   add_s/add_co      result from the external adder
//   out_valid/out_ready result slice handshake
//   out_s             result slice
//   out_last          result slice is the final slice of its word
//   out_co            final carry-out; 0 unless out_last
// -----------------------------------------------------------------------------
module add_byte_sequencer #(
    parameter int WIDTH  = 8,
    parameter int NBYTES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             ci_init,
`ifdef SEQ_SUB_EN
    input  logic             in_sub,
`endif
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_ci,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_last,
    output logic             out_co
);

    localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic {
        FIRST,
        MID
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_slice_cnt;
    logic [CNT_W-1:0]   w_slice_cnt_nxt;
    logic               r_carry;
    logic               w_carry_nxt;
    logic               w_xfer;
    logic               w_last;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_s;
    logic               r_out_last;
    logic               r_out_co;
`ifdef SEQ_SUB_EN
    logic               r_sub;
    logic               w_sub;
`endif

    // Single-entry output register: accept whenever it is empty or draining.
    assign in_ready = !r_out_valid || out_ready;
    assign w_xfer   = in_valid && in_ready;
    assign w_last   = (r_slice_cnt == CNT_W'(NBYTES - 1));

    assign add_a = in_a;

`ifdef SEQ_SUB_EN
    // Slice 0 takes the subtract select live; later slices use the held copy.
    assign w_sub  = (r_state == FIRST) ? in_sub : r_sub;
    assign add_b  = w_sub ? ~in_b : in_b;
    assign add_ci = (r_state == FIRST) ? (in_sub ? 1'b1 : ci_init) : r_carry;
`else
    assign add_b  = in_b;
    assign add_ci = (r_state == FIRST) ? ci_init : r_carry;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_slice_cnt_nxt = r_slice_cnt;
        w_carry_nxt     = r_carry;
        if (w_xfer) begin
            if (w_last) begin
                w_state_nxt     = FIRST;
                w_slice_cnt_nxt = '0;
                w_carry_nxt     = 1'b0;
            end else begin
                w_state_nxt     = MID;
                w_slice_cnt_nxt = r_slice_cnt + CNT_W'(1);
                w_carry_nxt     = add_co;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= FIRST;
            r_slice_cnt <= '0;
            r_carry     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_slice_cnt <= w_slice_cnt_nxt;
            r_carry     <= w_carry_nxt;
        end
    end

`ifdef SEQ_SUB_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sub <= 1'b0;
        end else if (w_xfer) begin
            r_sub <= w_last ? 1'b0 : w_sub;
        end
    end
`endif

    // A load takes priority over a drain so back-to-back slices keep
    // out_valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_s     <= '0;
            r_out_last  <= 1'b0;
            r_out_co    <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_s     <= add_s;
            r_out_last  <= w_last;
            r_out_co    <= w_last ? add_co : 1'b0;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_s     = r_out_s;
    assign out_last  = r_out_last;
    assign out_co    = r_out_co;

endmodule

// File: tb/tb_add_byte_sequencer.sv
module tb_add_byte_sequencer;

    localparam int WIDTH  = 8;
    localparam int NBYTES = 4;
    localparam int TW     = WIDTH * NBYTES;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             ci_init = 1'b0;
    logic             in_sub = 1'b0;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_ci;
    logic [WIDTH-1:0] add_s;
    logic             add_co;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_s;
    logic             out_last;
    logic             out_co;

    int checks = 0;
    int errors = 0;
    bit random_bp = 1'b0;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             last;
        logic             co;
    } exp_t;

    exp_t exp_q[$];

    add_byte_sequencer #(.WIDTH(WIDTH), .NBYTES(NBYTES)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .ci_init  (ci_init),
`ifdef SEQ_SUB_EN
        .in_sub   (in_sub),
`endif
        .add_a    (add_a),
        .add_b    (add_b),
        .add_ci   (add_ci),
        .add_s    (add_s),
        .add_co   (add_co),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_s    (out_s),
        .out_last (out_last),
        .out_co   (out_co)
    );

    // External ripple-carry adder stand-in.
    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-word reference: the full-width sum, split into slices afterwards.
    task automatic push_word(input logic [TW-1:0] a, input logic [TW-1:0] b,
                             input logic ci, input logic sub);
        logic [TW:0]   full;
        logic [TW-1:0] bb;
        logic          cin;
        exp_t          e;
        bb   = sub ? ~b : b;
        cin  = sub ? 1'b1 : ci;
        full = {1'b0, a} + {1'b0, bb} + {{TW{1'b0}}, cin};
        for (int i = 0; i < NBYTES; i++) begin
            e.s    = WIDTH'(full[TW-1:0] >> (i * WIDTH));
            e.last = (i == NBYTES - 1);
            e.co   = e.last ? full[TW] : 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // Drive one slice and hold it until it transfers. ci/sub are only
    // meaningful on slice 0; other slices get random junk there.
    task automatic send_slice(input logic [TW-1:0] a, input logic [TW-1:0] b,
                              input logic ci, input logic sub, input int idx);
        int n;
        in_valid = 1'b1;
        in_a     = WIDTH'(a >> (idx * WIDTH));
        in_b     = WIDTH'(b >> (idx * WIDTH));
        ci_init  = (idx == 0) ? ci : 1'($urandom);
        in_sub   = (idx == 0) ? sub : 1'($urandom);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [TW-1:0] a, input logic [TW-1:0] b,
                             input logic ci, input logic sub, input bit gaps);
        push_word(a, b, ci, sub);
        for (int i = 0; i < NBYTES; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_slice(a, b, ci, sub, i);
        end
    endtask

    // Monitor: pops one expectation for every result slice that drains.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none at %0t", out_s, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_s", 32'(out_s), 32'(e.s));
                chk("out_last", 32'(out_last), 32'(e.last));
                chk("out_co", 32'(out_co), 32'(e.co));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (random_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int n;
        // Reset values.
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_s", 32'(out_s), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_co", 32'(out_co), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed words, full throughput.
        send_word(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b0);
        send_word(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
        send_word(32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0);
        send_word(32'h12345678, 32'h0000FFFF, 1'b1, 1'b0, 1'b0);

        // Backpressure: hold out_ready low for 3 cycles after slice 0.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        push_word(32'h01020304, 32'h10203040, 1'b0, 1'b0);
        send_slice(32'h01020304, 32'h10203040, 1'b0, 1'b0, 0);
        in_valid = 1'b1;
        in_a     = 8'h03;
        in_b     = 8'h30;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_s", 32'(out_s), 32'h44);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 1; i < NBYTES; i++) send_slice(32'h01020304, 32'h10203040, 1'b0, 1'b0, i);

        // Reset mid-word discards the partial word.
        push_word(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0);
        send_slice(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 0);
        send_slice(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_word(32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0);

`ifdef SEQ_SUB_EN
        send_word(32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b0);
        send_word(32'h00000007, 32'h00000005, 1'b0, 1'b1, 1'b0);
`endif

        // Randomized words with random backpressure and input gaps.
        random_bp = 1'b1;
        for (int w = 0; w < 40; w++) begin
            logic sub;
`ifdef SEQ_SUB_EN
            sub = 1'($urandom);
`else
            sub = 1'b0;
`endif
            send_word($urandom, $urandom, 1'($urandom), sub, 1'b1);
        end
        for (int w = 0; w < 6; w++) begin
            send_word(32'hFFFFFFFF, $urandom_range(0, 3), 1'($urandom), 1'b0, 1'b1);
        end

        // Drain.
        @(posedge clk);
        #1;
        random_bp = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_remaining", 32'(exp_q.size()), 0);
        chk("final_out_valid", 32'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_byte_sequencer.md
Name: add_byte_sequencer

Overview:
- Byte-serial multi-byte adder controller; sits directly upstream and downstream of the team's WIDTH-bit ripple-carry adder, which is instantiated outside this block.
- Accepts operand byte pairs (LSB first) over a valid/ready stream, drives the adder's a/b/ci inputs, and captures the adder's sum and carry-out into an output register.
- Carries the adder's carry-out from byte to byte, so an NBYTES×WIDTH-bit addition is built from one WIDTH-bit adder.
- Emits result bytes on a valid/ready stream, with a last marker and the final carry.

Parameters:
WIDTH, 8, bit width of one operand slice; must match the external adder.
NBYTES, 4, slices per word; must be ≥1.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand slice valid.
in_ready  output  1  block can accept a slice this cycle.
in_a  input  WIDTH  operand A slice.
in_b  input  WIDTH  operand B slice.
ci_init  input  1  carry-in for the word; sampled only on slice 0.
add_a  output  WIDTH  to adder a; combinational from in_a.
add_b  output  WIDTH  to adder b; combinational from in_b.
add_ci  output  1  to adder ci.
add_s  input  WIDTH  from adder s.
add_co  input  1  from adder co.
out_valid  output  1  result slice valid.
out_ready  input  1  downstream accepts result slice.
out_s  output  WIDTH  result slice.
out_last  output  1  result slice is slice NBYTES-1 of its word.
out_co  output  1  final carry-out; meaningful only when out_last=1, else 0.

Behaviour:
- Interface is fixed: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values:
  - out_valid=0, out_s=0, out_last=0, out_co=0.
  - carry_q=0, slice_cnt=0, state=FIRST.
- Reset mid-word discards the partial word. The next accepted slice is slice 0.
- Handshake:
  - in_ready = !out_valid || out_ready (single-entry pipeline register).
  - A slice transfers when in_valid && in_ready.
  - Once out_valid=1, out_s, out_last and out_co hold stable until out_valid && out_ready.
- Adder drive:
  - add_a=in_a, add_b=in_b at all times.
  - add_ci = ci_init in state FIRST; add_ci = carry_q in state MID.
- FSM, two states:
  - FIRST: waiting for slice 0.
  - MID: slices 1..NBYTES-1.
- On each transfer:
  - out_s<=add_s; carry_q<=add_co; out_valid<=1.
  - out_last<=(slice_cnt==NBYTES-1).
  - out_co<=add_co if last, else 0.
  - If last: slice_cnt<=0, state<=FIRST, carry_q<=0.
  - Otherwise: slice_cnt+1, state<=MID.
- If NBYTES=1, every slice is both first and last; the FSM stays in FIRST.
- Output register:
  - With no transfer, out_valid clears on out_ready; otherwise it holds.
  - A transfer and a drain in the same cycle load the new slice, so out_valid stays 1. This gives full throughput of one slice per cycle.
- Latency: 1 cycle from input transfer to out_valid.
- Carry never leaks between words; slice 0 always uses ci_init.
- slice_cnt width is clog2(NBYTES), minimum 1 bit; it wraps only via the last-slice reset to 0.

Optional Feature:
Macro SEQ_SUB_EN.
- Defined:
  - Adds input in_sub (1 bit), sampled on slice 0 and held in sub_q for the rest of the word.
  - While subtracting: add_b=~in_b, and slice-0 add_ci = 1 (ci_init ignored).
  - out_co=1 means no borrow.
  - sub_q clears on reset and at word end.
- Undefined: no in_sub port, add_b=in_b always.

Test Plan:
- NBYTES=4, A=0x000000FF, B=0x00000001, ci_init=0, out_ready=1 → out_s 00,01,00,00 on consecutive cycles; out_last only on the 4th; out_co=0.
- A=0xFFFFFFFF, B=0x00000001 → out_s 00,00,00,00; 4th slice out_last=1, out_co=1.
- Back-to-back words: first FFFFFFFF+1, then 00000000+00000000 with ci_init=0 → second word all 00, out_co=0 (no carry leak).
- Backpressure: out_ready=0 for 3 cycles after slice 0 of 0x01020304+0x10203040:
  - in_ready=0 and out_s=0x44 stable throughout.
  - After release, slices 33,22,11 arrive with none lost.
- Assert rst after 2 slices of a word → out_valid=0 immediately. Then 0x00000002+0x00000003 yields 05,00,00,00 with correct out_last.
- SEQ_SUB_EN: 0x00000005 − 0x00000007 with in_sub=1 → FE,FF,FF,FF, out_co=0. Also 7−5 → 02,00,00,00, out_co=1.
